// File: rtl/first_kmer_dispatch_pkg.sv
// Shared types and constants for the first-k-mer dispatch front end.
// The optional watchdog in first_kmer_dispatch is enabled by CORRECT1_TIMEOUT_EN.
package kmer_corr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCORE,
        ST_DISPATCH,
        ST_CORRECT,
        ST_READOUT
    } state_t;

    localparam logic MODE_EXHAUSTIVE = 1'b0;
    localparam logic MODE_LOWQ       = 1'b1;

    function automatic int pow2(input int bits);
        return 1 << bits;
    endfunction

    localparam int MAX_READ_WIDTH = pow2(8);
    localparam int MAX_KMER_WIDTH = pow2(6);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/first_kmer_dispatch_low_q_counter.sv
// Combinational count of low-quality bases (quality < threshold) among the
// first kmerLength bases of a read.
module low_q_counter
    import kmer_corr_pkg::*;
#(
    parameter int MAX_READ_BIT_WIDTH = 8,
    parameter int MAX_KMER_BIT_WIDTH = 6,
    parameter int QUALITY_WIDTH      = 2,
    localparam int MRW  = pow2(MAX_READ_BIT_WIDTH),
    localparam int MKW  = pow2(MAX_KMER_BIT_WIDTH),
    localparam int CW   = MAX_KMER_BIT_WIDTH + 1,
    localparam int SCAN = (MKW < MRW) ? MKW : MRW
) (
    input  logic [QUALITY_WIDTH*MRW-1:0]  i_quality,
    input  logic [QUALITY_WIDTH-1:0]      i_threshold,
    input  logic [MAX_KMER_BIT_WIDTH-1:0] i_kmer_length,
    output logic [CW-1:0]                 o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < SCAN; i++) begin
            if ((i < int'(i_kmer_length)) &&
                (i_quality[i*QUALITY_WIDTH +: QUALITY_WIDTH] < i_threshold)) begin
                o_count = o_count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/first_kmer_dispatch.sv
// Per-read front end: scores the first k-mer, passes through or runs one correction
// engine, buffers its candidates and presents them. Watchdog: CORRECT1_TIMEOUT_EN.
module first_kmer_dispatch
    import kmer_corr_pkg::*;
#(
    parameter int MAX_READ_BIT_WIDTH = 8,
    parameter int MAX_KMER_BIT_WIDTH = 6,
    parameter int QUALITY_WIDTH      = 2,
    parameter int CAND_DEPTH_BITS    = 5,
    parameter int LOWQ_LIMIT         = 3,
    parameter int TIMEOUT_CYCLES     = 4096,
    localparam int MRW = pow2(MAX_READ_BIT_WIDTH),
    localparam int MKW = pow2(MAX_KMER_BIT_WIDTH)
) (
    input  logic                          i_clk,
    input  logic                          i_rstb,
    input  logic [2*MRW-1:0]              i_read,
    input  logic [QUALITY_WIDTH*MRW-1:0]  i_quality,
    input  logic [QUALITY_WIDTH-1:0]      i_qualityThreshold,
    input  logic [MAX_READ_BIT_WIDTH-1:0] i_startPosition,
    input  logic [MAX_READ_BIT_WIDTH-1:0] i_endPosition,
    input  logic [MAX_READ_BIT_WIDTH-1:0] i_readLength,
    input  logic [MAX_KMER_BIT_WIDTH-1:0] i_kmerLength,
    input  logic                          i_readValid,
    output logic                          o_ready4Read,
    output logic [2*MRW-1:0]              o_engRead,
    output logic [QUALITY_WIDTH*MRW-1:0]  o_engQuality,
    output logic [1:0]                    o_engStart,
    output logic [1:0]                    o_engAbort,
    input  logic [1:0][2*MRW-1:0]         i_engCandidate,
    input  logic [1:0]                    i_engCandidateValid,
    input  logic [1:0]                    i_engDone,
    input  logic [1:0][2*MKW-1:0]         i_engKmer,
    input  logic [1:0]                    i_engKmerValid,
    output logic                          o_engReady4Kmer,
    output logic [2*MKW-1:0]              o_kmer,
    output logic                          o_kmerValid,
    input  logic                          i_ready4Kmer,
    input  logic                          i_queryResult,
    input  logic                          i_queryResultValid,
    output logic                          o_engQueryResult,
    output logic [1:0]                    o_engQueryResultValid,
    output logic [2*MRW-1:0]              o_candidate,
    output logic                          o_candidateValid,
    input  logic                          i_ready4Candidate,
    output logic [CAND_DEPTH_BITS:0]      o_candidateNum,
    output logic                          o_candidateNumValid,
    output logic                          o_success,
    output logic [7:0]                    o_dropped,
    output logic                          o_timedOut
);

    localparam int CW    = MAX_KMER_BIT_WIDTH + 1;
    localparam int DEPTH = pow2(CAND_DEPTH_BITS);
    localparam logic [CW-1:0] LOWQ_LIM_C = CW'(LOWQ_LIMIT);

    state_t                          r_state, w_next;
    logic [2*MRW-1:0]                r_read;
    logic [QUALITY_WIDTH*MRW-1:0]    r_quality;
    logic [QUALITY_WIDTH-1:0]        r_thr;
    logic [MAX_READ_BIT_WIDTH-1:0]   r_start, r_end, r_len;
    logic [MAX_KMER_BIT_WIDTH-1:0]   r_k;
    logic [CW-1:0]                   r_lowq, w_lowq;
    logic                            r_mode, w_mode;
    logic [CAND_DEPTH_BITS:0]        r_cand_num, r_wr_ptr, r_rd_ptr;
    logic [7:0]                      r_dropped;
    logic [2*MRW-1:0]                r_fifo [DEPTH];
    logic                            w_correct_first, w_full, w_empty;
    logic                            w_push, w_push_eng, w_push_read, w_drop, w_pop;
    logic                            w_cand_valid, w_done, w_timeout;
    logic [2*MRW-1:0]                w_push_data;

    low_q_counter #(
        .MAX_READ_BIT_WIDTH(MAX_READ_BIT_WIDTH),
        .MAX_KMER_BIT_WIDTH(MAX_KMER_BIT_WIDTH),
        .QUALITY_WIDTH     (QUALITY_WIDTH)
    ) u_low_q_counter (
        .i_quality    (r_quality),
        .i_threshold  (r_thr),
        .i_kmer_length(r_k),
        .o_count      (w_lowq)
    );

    // Wrap-around subtraction is intended: readLength==0 pairs with end==all-ones.
    assign w_correct_first = (r_start == '0) &&
                             (r_end == r_len - MAX_READ_BIT_WIDTH'(1));
    assign w_mode       = ((r_lowq != '0) && (r_lowq <= LOWQ_LIM_C)) ? MODE_LOWQ : MODE_EXHAUSTIVE;
    assign w_full       = (r_wr_ptr[CAND_DEPTH_BITS] != r_rd_ptr[CAND_DEPTH_BITS]) &&
                          (r_wr_ptr[CAND_DEPTH_BITS-1:0] == r_rd_ptr[CAND_DEPTH_BITS-1:0]);
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_cand_valid = i_engCandidateValid[r_mode];
    assign w_done       = i_engDone[r_mode];
    assign w_push_read  = (r_state == ST_SCORE) && !w_correct_first;
    assign w_push       = w_push_read | w_push_eng;
    assign w_push_data  = w_push_read ? r_read : i_engCandidate[r_mode];

    assign o_ready4Read = (r_state == ST_IDLE);
    assign o_engRead    = r_read;
    assign o_engQuality = r_quality;
    assign o_candidate  = o_candidateValid ? r_fifo[r_rd_ptr[CAND_DEPTH_BITS-1:0]] : '0;
    assign o_candidateNum = r_cand_num;
    assign o_dropped    = r_dropped;

`ifdef CORRECT1_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCW-1:0] r_tcnt;
    logic           r_timed_out;

    assign w_timeout  = (r_state == ST_CORRECT) && !w_done &&
                        (r_tcnt == TCW'(TIMEOUT_CYCLES - 1));
    assign o_timedOut = r_timed_out;

    always_ff @(posedge i_clk) begin
        if (i_rstb) begin
            r_tcnt      <= '0;
            r_timed_out <= 1'b0;
        end else begin
            if (r_state == ST_DISPATCH) r_tcnt <= '0;
            else if (r_state == ST_CORRECT) r_tcnt <= r_tcnt + TCW'(1);
            if (r_state == ST_IDLE && i_readValid) r_timed_out <= 1'b0;
            else if (w_timeout) r_timed_out <= 1'b1;
        end
    end
`else
    assign w_timeout  = 1'b0;
    assign o_timedOut = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rstb) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next                = r_state;
        o_engStart            = '0;
        o_engAbort            = '0;
        o_engReady4Kmer       = 1'b0;
        o_kmer                = '0;
        o_kmerValid           = 1'b0;
        o_engQueryResult      = 1'b0;
        o_engQueryResultValid = '0;
        o_candidateValid      = 1'b0;
        o_candidateNumValid   = 1'b0;
        o_success             = 1'b0;
        w_push_eng            = 1'b0;
        w_drop                = 1'b0;
        w_pop                 = 1'b0;
        case (r_state)
            ST_IDLE: if (i_readValid) w_next = ST_SCORE;
            ST_SCORE: w_next = w_correct_first ? ST_DISPATCH : ST_READOUT;
            ST_DISPATCH: begin
                o_engStart[w_mode] = 1'b1;
                w_next             = ST_CORRECT;
            end
            ST_CORRECT: begin
                o_kmer                        = i_engKmer[r_mode];
                o_kmerValid                   = i_engKmerValid[r_mode];
                o_engReady4Kmer               = i_ready4Kmer;
                o_engQueryResult              = i_queryResult;
                o_engQueryResultValid[r_mode] = i_queryResultValid;
                w_push_eng                    = w_cand_valid && !w_full;
                w_drop                        = w_cand_valid && w_full;
                if (w_done) begin
                    w_next = ST_READOUT;
                end else if (w_timeout) begin
                    o_engAbort[r_mode] = 1'b1;
                    w_next             = ST_READOUT;
                end
            end
            ST_READOUT: begin
                o_candidateNumValid = 1'b1;
                o_success           = (r_cand_num != '0);
                o_candidateValid    = !w_empty;
                w_pop               = !w_empty && i_ready4Candidate;
                if (w_empty) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rstb) begin
            r_read     <= '0;
            r_quality  <= '0;
            r_thr      <= '0;
            r_start    <= '0;
            r_end      <= '0;
            r_len      <= '0;
            r_k        <= '0;
            r_lowq     <= '0;
            r_mode     <= MODE_EXHAUSTIVE;
            r_cand_num <= '0;
            r_dropped  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (r_state == ST_IDLE && i_readValid) begin
                r_read     <= i_read;
                r_quality  <= i_quality;
                r_thr      <= i_qualityThreshold;
                r_start    <= i_startPosition;
                r_end      <= i_endPosition;
                r_len      <= i_readLength;
                r_k        <= i_kmerLength;
                r_cand_num <= '0;
                r_dropped  <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end
            if (r_state == ST_SCORE)    r_lowq <= w_lowq;
            if (r_state == ST_DISPATCH) r_mode <= w_mode;
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_cand_num <= r_cand_num + 1'b1;
            end
            if (w_drop) r_dropped <= sat_inc8(r_dropped);
            if (w_pop)  r_rd_ptr  <= r_rd_ptr + 1'b1;
        end
    end

    // Storage only; emptiness is tracked by the pointers, so no reset needed here.
    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wr_ptr[CAND_DEPTH_BITS-1:0]] <= w_push_data;
    end

endmodule

// File: tb/tb_first_kmer_dispatch.sv
// Directed self-checking bench for first_kmer_dispatch (default parameters,
// watchdog limit shortened to 16 cycles for the CORRECT1_TIMEOUT_EN build).
module tb_first_kmer_dispatch;

    localparam int RW = 512;
    localparam int QW = 512;
    localparam int KW = 128;
    localparam logic [QW-1:0] Q_HI  = {256{2'b11}};
    localparam logic [QW-1:0] Q_THR = {256{2'b10}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rstb;
    logic [RW-1:0]    read;
    logic [QW-1:0]    quality;
    logic [1:0]       thr;
    logic [7:0]       st_pos, en_pos, rd_len;
    logic [5:0]       k_len;
    logic             read_valid, ready4read;
    logic [RW-1:0]    eng_read;
    logic [QW-1:0]    eng_qual;
    logic [1:0]       eng_start, eng_abort;
    logic [1:0][RW-1:0] eng_cand;
    logic [1:0]       eng_cand_valid, eng_done;
    logic [1:0][KW-1:0] eng_kmer;
    logic [1:0]       eng_kmer_valid;
    logic             eng_ready4kmer;
    logic [KW-1:0]    kmer;
    logic             kmer_valid, ready4kmer, query_result, query_result_valid;
    logic             eng_query_result;
    logic [1:0]       eng_query_result_valid;
    logic [RW-1:0]    cand;
    logic             cand_valid, ready4cand;
    logic [5:0]       cand_num;
    logic             cand_num_valid, success;
    logic [7:0]       dropped;
    logic             timed_out;

    int n_cmp = 0;
    int n_bad = 0;

    first_kmer_dispatch #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk), .i_rstb(rstb),
        .i_read(read), .i_quality(quality), .i_qualityThreshold(thr),
        .i_startPosition(st_pos), .i_endPosition(en_pos), .i_readLength(rd_len),
        .i_kmerLength(k_len), .i_readValid(read_valid), .o_ready4Read(ready4read),
        .o_engRead(eng_read), .o_engQuality(eng_qual),
        .o_engStart(eng_start), .o_engAbort(eng_abort),
        .i_engCandidate(eng_cand), .i_engCandidateValid(eng_cand_valid), .i_engDone(eng_done),
        .i_engKmer(eng_kmer), .i_engKmerValid(eng_kmer_valid), .o_engReady4Kmer(eng_ready4kmer),
        .o_kmer(kmer), .o_kmerValid(kmer_valid), .i_ready4Kmer(ready4kmer),
        .i_queryResult(query_result), .i_queryResultValid(query_result_valid),
        .o_engQueryResult(eng_query_result), .o_engQueryResultValid(eng_query_result_valid),
        .o_candidate(cand), .o_candidateValid(cand_valid), .i_ready4Candidate(ready4cand),
        .o_candidateNum(cand_num), .o_candidateNumValid(cand_num_valid), .o_success(success),
        .o_dropped(dropped), .o_timedOut(timed_out)
    );

    function automatic logic [RW-1:0] cand_pat(input int i);
        logic [31:0] w;
        w = 32'hC0DE0000 + 32'(i);
        return {16{w}};
    endfunction

    function automatic logic [QW-1:0] q_low(input logic [QW-1:0] q, input int idx);
        logic [QW-1:0] r;
        r = q;
        r[idx*2 +: 2] = 2'b00;
        return r;
    endfunction

    task automatic clear_inputs;
        read = '0; quality = '0; thr = '0; st_pos = '0; en_pos = '0; rd_len = '0;
        k_len = '0; read_valid = 1'b0; eng_cand = '0; eng_cand_valid = '0; eng_done = '0;
        eng_kmer = '0; eng_kmer_valid = '0; ready4kmer = 1'b0; query_result = 1'b0;
        query_result_valid = 1'b0; ready4cand = 1'b0;
    endtask

    // Returns at the negedge where the DUT sits in SCORE (T+1).
    task automatic send_read(input logic [RW-1:0] rd, input logic [QW-1:0] q,
                             input logic [7:0] st, input logic [7:0] en, input logic [7:0] len);
        @(negedge clk);
        read = rd; quality = q; thr = 2'b10; st_pos = st; en_pos = en; rd_len = len;
        k_len = 6'd32; read_valid = 1'b1;
        @(negedge clk);
        read_valid = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rstb = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (ready4read !== 1'b1) begin n_bad++; $display("FAIL reset_ready4Read got %b want 1", ready4read); end
        n_cmp++; if (eng_start !== 2'b00) begin n_bad++; $display("FAIL reset_engStart got %b want 00", eng_start); end
        n_cmp++; if (eng_abort !== 2'b00) begin n_bad++; $display("FAIL reset_engAbort got %b want 00", eng_abort); end
        n_cmp++; if (cand_valid !== 1'b0) begin n_bad++; $display("FAIL reset_candidateValid got %b want 0", cand_valid); end
        n_cmp++; if (cand_num !== 6'd0) begin n_bad++; $display("FAIL reset_candidateNum got %0d want 0", cand_num); end
        n_cmp++; if (cand_num_valid !== 1'b0) begin n_bad++; $display("FAIL reset_candidateNumValid got %b want 0", cand_num_valid); end
        n_cmp++; if (success !== 1'b0) begin n_bad++; $display("FAIL reset_success got %b want 0", success); end
        n_cmp++; if (dropped !== 8'd0) begin n_bad++; $display("FAIL reset_dropped got %0d want 0", dropped); end
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL reset_timedOut got %b want 0", timed_out); end
        n_cmp++; if (kmer_valid !== 1'b0 || eng_query_result_valid !== 2'b00) begin n_bad++; $display("FAIL reset_kmer_strobes got %b/%b want 0/00", kmer_valid, eng_query_result_valid); end
        n_cmp++; if (cand !== '0 || eng_read !== '0 || kmer !== '0) begin n_bad++; $display("FAIL reset_data got nonzero want all zeros"); end
        rstb = 1'b0;
    endtask

    // Corrected read that the engine finishes with no candidates.
    task automatic run_dispatch(input logic [QW-1:0] q, input logic [7:0] en, input logic [7:0] len,
                                input logic [1:0] exp_start, input string nm);
        send_read({16{32'h1234ABCD}}, q, 8'd0, en, len);
        n_cmp++; if (eng_start !== 2'b00) begin n_bad++; $display("FAIL %s_score_engStart got %b want 00", nm, eng_start); end
        @(negedge clk);
        n_cmp++; if (eng_start !== exp_start) begin n_bad++; $display("FAIL %s_engStart got %b want %b", nm, eng_start, exp_start); end
        @(negedge clk);
        n_cmp++; if (eng_start !== 2'b00 || cand_num_valid !== 1'b0) begin n_bad++; $display("FAIL %s_correct_entry got start=%b numValid=%b want 00/0", nm, eng_start, cand_num_valid); end
        eng_done = exp_start;
        @(negedge clk);
        eng_done = 2'b00;
        n_cmp++; if (cand_num_valid !== 1'b1 || cand_num !== 6'd0 || success !== 1'b0 || cand_valid !== 1'b0)
            begin n_bad++; $display("FAIL %s_empty_readout got v=%b n=%0d s=%b cv=%b want 1/0/0/0", nm, cand_num_valid, cand_num, success, cand_valid); end
        @(negedge clk);
        n_cmp++; if (ready4read !== 1'b1) begin n_bad++; $display("FAIL %s_back_to_idle got %b want 1", nm, ready4read); end
    endtask

    task automatic test_dispatch_mode;
        logic [QW-1:0] q;
        run_dispatch(Q_HI, 8'd99, 8'd100, 2'b01, "lowq0");
        q = q_low(q_low(Q_HI, 3), 10);
        run_dispatch(q, 8'd99, 8'd100, 2'b10, "lowq2");
        q = q_low(q_low(q_low(Q_HI, 0), 1), 31);
        run_dispatch(q, 8'd99, 8'd100, 2'b10, "lowq3_edge");
        q = q_low(q, 20);
        run_dispatch(q, 8'd99, 8'd100, 2'b01, "lowq4");
        q = q_low(q, 21);
        run_dispatch(q, 8'd99, 8'd100, 2'b01, "lowq5");
        q = q_low(q_low(Q_HI, 32), 40);
        run_dispatch(q, 8'd99, 8'd100, 2'b01, "low_past_k");
        run_dispatch(Q_THR, 8'd99, 8'd100, 2'b01, "q_eq_thr");
        run_dispatch(q_low(Q_THR, 0), 8'd99, 8'd100, 2'b10, "lowq1");
        run_dispatch(Q_HI, 8'd255, 8'd0, 2'b01, "len0_wrap");
    endtask

    task automatic test_correct_exhaustive;
        send_read({16{32'h5A5A0F0F}}, Q_HI, 8'd0, 8'd99, 8'd100);
        @(negedge clk);
        n_cmp++; if (eng_start !== 2'b01) begin n_bad++; $display("FAIL exh_engStart got %b want 01", eng_start); end
        @(negedge clk);
        eng_kmer[0] = {4{32'h0000AAAA}}; eng_kmer[1] = {4{32'h0000BBBB}}; eng_kmer_valid = 2'b11;
        ready4kmer = 1'b1; query_result = 1'b1; query_result_valid = 1'b1;
        #1;
        n_cmp++; if (kmer !== {4{32'h0000AAAA}} || kmer_valid !== 1'b1) begin n_bad++; $display("FAIL route_kmer got %h/%b want engine0 kmer/1", kmer, kmer_valid); end
        n_cmp++; if (eng_ready4kmer !== 1'b1) begin n_bad++; $display("FAIL route_ready4Kmer got %b want 1", eng_ready4kmer); end
        n_cmp++; if (eng_query_result_valid !== 2'b01 || eng_query_result !== 1'b1) begin n_bad++; $display("FAIL route_query got %b/%b want 01/1", eng_query_result_valid, eng_query_result); end
        eng_kmer_valid = 2'b10;
        #1;
        n_cmp++; if (kmer_valid !== 1'b0) begin n_bad++; $display("FAIL route_other_kmerValid got %b want 0", kmer_valid); end
        eng_kmer_valid = 2'b00; ready4kmer = 1'b0; query_result = 1'b0; query_result_valid = 1'b0;
        eng_cand[0] = cand_pat(0); eng_cand[1] = cand_pat(99); eng_cand_valid = 2'b11;
        @(negedge clk);
        eng_cand[0] = cand_pat(1); eng_cand_valid = 2'b01; eng_done = 2'b10;
        @(negedge clk);
        eng_cand[0] = cand_pat(2); eng_cand_valid = 2'b01; eng_done = 2'b01;
        @(negedge clk);
        eng_cand_valid = 2'b00; eng_done = 2'b00;
        n_cmp++; if (cand_num_valid !== 1'b1 || cand_num !== 6'd3 || success !== 1'b1) begin n_bad++; $display("FAIL exh_count got v=%b n=%0d s=%b want 1/3/1", cand_num_valid, cand_num, success); end
        n_cmp++; if (cand_valid !== 1'b1 || cand !== cand_pat(0)) begin n_bad++; $display("FAIL exh_first_cand got %b/%h want 1/%h", cand_valid, cand[31:0], 32'hC0DE0000); end
        @(negedge clk);
        n_cmp++; if (cand !== cand_pat(0) || cand_num !== 6'd3) begin n_bad++; $display("FAIL exh_hold got %h/%0d want %h/3", cand[31:0], cand_num, 32'hC0DE0000); end
        ready4cand = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (cand_valid !== 1'b1 || cand !== cand_pat(i)) begin n_bad++; $display("FAIL exh_pop%0d got %b/%h want 1/%h", i, cand_valid, cand[31:0], cand_pat(i)); end
            @(negedge clk);
        end
        n_cmp++; if (cand_valid !== 1'b0 || cand_num_valid !== 1'b1) begin n_bad++; $display("FAIL exh_drained got cv=%b nv=%b want 0/1", cand_valid, cand_num_valid); end
        @(negedge clk);
        ready4cand = 1'b0;
        n_cmp++; if (ready4read !== 1'b1) begin n_bad++; $display("FAIL exh_idle got %b want 1", ready4read); end
    endtask

    task automatic test_passthrough;
        logic [RW-1:0] rd;
        rd = {16{32'hFACE0001}};
        send_read(rd, Q_HI, 8'd5, 8'd99, 8'd100);
        n_cmp++; if (eng_start !== 2'b00 || cand_num_valid !== 1'b0) begin n_bad++; $display("FAIL pass_score got %b/%b want 00/0", eng_start, cand_num_valid); end
        @(negedge clk);
        n_cmp++; if (eng_start !== 2'b00) begin n_bad++; $display("FAIL pass_engStart got %b want 00", eng_start); end
        n_cmp++; if (cand_valid !== 1'b1 || cand !== rd) begin n_bad++; $display("FAIL pass_candidate got %b/%h want 1/%h", cand_valid, cand[31:0], rd[31:0]); end
        n_cmp++; if (cand_num !== 6'd1 || success !== 1'b1 || cand_num_valid !== 1'b1) begin n_bad++; $display("FAIL pass_count got %0d/%b/%b want 1/1/1", cand_num, success, cand_num_valid); end
        ready4cand = 1'b1;
        @(negedge clk);
        n_cmp++; if (cand_valid !== 1'b0) begin n_bad++; $display("FAIL pass_drained got %b want 0", cand_valid); end
        @(negedge clk);
        ready4cand = 1'b0;
        n_cmp++; if (ready4read !== 1'b1) begin n_bad++; $display("FAIL pass_idle got %b want 1", ready4read); end
        rd = {16{32'hFACE0002}};
        send_read(rd, Q_HI, 8'd0, 8'd98, 8'd100);
        @(negedge clk);
        n_cmp++; if (eng_start !== 2'b00 || cand_valid !== 1'b1 || cand !== rd) begin n_bad++; $display("FAIL pass_end_short got %b/%b want 00/1", eng_start, cand_valid); end
        ready4cand = 1'b1;
        repeat (2) @(negedge clk);
        ready4cand = 1'b0;
        n_cmp++; if (ready4read !== 1'b1) begin n_bad++; $display("FAIL pass_end_short_idle got %b want 1", ready4read); end
    endtask

    task automatic test_overflow;
        send_read({16{32'h0BADF00D}}, Q_HI, 8'd0, 8'd99, 8'd100);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            eng_cand[0] = cand_pat(100 + i); eng_cand_valid = 2'b01;
            @(negedge clk);
        end
        eng_cand_valid = 2'b00; eng_done = 2'b01;
        @(negedge clk);
        eng_done = 2'b00;
        n_cmp++; if (cand_num !== 6'd32) begin n_bad++; $display("FAIL ovf_candidateNum got %0d want 32", cand_num); end
        n_cmp++; if (dropped !== 8'd8) begin n_bad++; $display("FAIL ovf_dropped got %0d want 8", dropped); end
        ready4cand = 1'b1;
        for (int i = 0; i < 32; i++) begin
            n_cmp++; if (cand_valid !== 1'b1 || cand !== cand_pat(100 + i)) begin n_bad++; $display("FAIL ovf_pop%0d got %b/%h want 1/%h", i, cand_valid, cand[31:0], cand_pat(100 + i)); end
            @(negedge clk);
        end
        n_cmp++; if (cand_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drained got %b want 0", cand_valid); end
        @(negedge clk);
        ready4cand = 1'b0;
        n_cmp++; if (ready4read !== 1'b1) begin n_bad++; $display("FAIL ovf_idle got %b want 1", ready4read); end
    endtask

    task automatic test_reset_mid;
        send_read({16{32'h77778888}}, Q_HI, 8'd0, 8'd99, 8'd100);
        n_cmp++; if (dropped !== 8'd0 || cand_num !== 6'd0) begin n_bad++; $display("FAIL newread_clear got %0d/%0d want 0/0", dropped, cand_num); end
        repeat (2) @(negedge clk);
        eng_kmer[0] = {4{32'h12341234}}; eng_kmer_valid = 2'b01;
        #1;
        n_cmp++; if (kmer_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_correct got %b want 1", kmer_valid); end
        rstb = 1'b1;
        @(negedge clk);
        n_cmp++; if (ready4read !== 1'b1 || kmer_valid !== 1'b0 || cand_num_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle got r=%b kv=%b nv=%b want 1/0/0", ready4read, kmer_valid, cand_num_valid); end
        rstb = 1'b0;
        eng_kmer_valid = 2'b00;
    endtask

`ifdef CORRECT1_TIMEOUT_EN
    task automatic test_timeout;
        int first;
        first = 0;
        send_read({16{32'h99990000}}, Q_HI, 8'd0, 8'd99, 8'd100);
        @(negedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (eng_abort != 2'b00 && first == 0) first = c;
            if (first != 0) break;
        end
        n_cmp++; if (first != 16) begin n_bad++; $display("FAIL timeout_abort_cycle got %0d want 16", first); end
        n_cmp++; if (eng_abort !== 2'b01) begin n_bad++; $display("FAIL timeout_abort_mode got %b want 01", eng_abort); end
        @(negedge clk);
        n_cmp++; if (timed_out !== 1'b1 || cand_num_valid !== 1'b1 || cand_num !== 6'd0) begin n_bad++; $display("FAIL timeout_readout got t=%b nv=%b n=%0d want 1/1/0", timed_out, cand_num_valid, cand_num); end
        @(negedge clk);
        n_cmp++; if (ready4read !== 1'b1) begin n_bad++; $display("FAIL timeout_idle got %b want 1", ready4read); end
    endtask
`else
    task automatic test_timeout;
        logic seen;
        seen = 1'b0;
        send_read({16{32'h99990000}}, Q_HI, 8'd0, 8'd99, 8'd100);
        @(negedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (eng_abort != 2'b00 || cand_num_valid != 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL no_watchdog_exit got %b want 0", seen); end
        eng_done = 2'b01;
        @(negedge clk);
        eng_done = 2'b00;
        n_cmp++; if (timed_out !== 1'b0 || cand_num_valid !== 1'b1) begin n_bad++; $display("FAIL no_watchdog_done got t=%b nv=%b want 0/1", timed_out, cand_num_valid); end
        @(negedge clk);
        n_cmp++; if (ready4read !== 1'b1) begin n_bad++; $display("FAIL no_watchdog_idle got %b want 1", ready4read); end
    endtask
`endif

    initial begin
        test_reset();
        test_dispatch_mode();
        test_correct_exhaustive();
        test_passthrough();
        test_overflow();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
